bounded_step_counter: RTL and testbench

Parametrised up/down counter with programmable step, bounded to [MIN, MAX], with a start/run/done control FSM. It supersedes the single-width counter for timer and sequencing uses. It adds range-clamped loading, a per-event `finish` pulse, a `busy` status, and a compile-time wrap-around option. It sits between control logic that issues `start`/`load` and consumers of `count`, `finish` and `at_bound`.

---
 rtl/bounded_step_counter.sv | 121 ++++++++++++
 tb/tb_bounded_step_counter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bounded_step_counter.sv
// bounded_step_counter: up/down counter with a programmable step, held inside
// the range [MIN, MAX] and driven by an IDLE/RUN/DONE control FSM.
// Build option: define BOUNDED_COUNTER_WRAP_EN so that a boundary event in RUN
// wraps to the opposite bound and keeps running, instead of saturating and
// stopping in DONE.
module bounded_step_counter #(
  parameter int unsigned            WIDTH  = 8,
  parameter int unsigned            STEP_W = 4,
  parameter logic [WIDTH-1:0]       MIN    = '0,
  parameter logic [WIDTH-1:0]       MAX    = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  din,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              finish,
  output logic              at_bound
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             finish_q, finish_d;

  // Arithmetic is carried one bit wider than the count so an overshoot past
  // MAX, or a step larger than the distance to MIN, is visible without
  // any modular wrap of the intermediate value.
  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] min_plus_step;
  logic           bound_event;
  logic [WIDTH-1:0] load_value;

  assign count_ext     = {1'b0, count_q};
  assign step_ext      = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum_ext       = count_ext + step_ext;
  assign min_plus_step = {1'b0, MIN} + step_ext;

  // Clamp the load value into the legal range before it reaches the count.
  always_comb begin
    load_value = din;
    if (din < MIN) begin
      load_value = MIN;
    end else if (din > MAX) begin
      load_value = MAX;
    end
  end

  // A step that would leave the range, or any step taken while already
  // sitting on the bound in the current direction, is a boundary event.
  always_comb begin
    bound_event = 1'b0;
    if (up_down) begin
      bound_event = (count_q == MAX) || (sum_ext > {1'b0, MAX});
    end else begin
      bound_event = (count_q == MIN) || (count_ext < min_plus_step);
    end
  end

  // Next-state logic: rst is handled in the register, then load > start > en.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    finish_d = 1'b0;
    if (load) begin
      count_d = load_value;
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      state_d = RUN;
    end else if ((state_q == RUN) && en) begin
      if (bound_event) begin
        finish_d = 1'b1;
`ifdef BOUNDED_COUNTER_WRAP_EN
        count_d  = up_down ? MIN : MAX;
`else
        count_d  = up_down ? MAX : MIN;
        state_d  = DONE;
`endif
      end else if (up_down) begin
        count_d = sum_ext[WIDTH-1:0];
      end else begin
        count_d = count_q - step_ext[WIDTH-1:0];
      end
    end
    busy_d = (state_d == RUN);
  end

  // State, count and status registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= MIN;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign count    = count_q;
  assign busy     = busy_q;
  assign finish   = finish_q;
  assign at_bound = up_down ? (count_q == MAX) : (count_q == MIN);

endmodule

// File: tb/tb_bounded_step_counter.sv
// Testbench for bounded_step_counter with WIDTH=8, STEP_W=4, MIN=10, MAX=50.
// Works in both builds; the wrap-around expectations are selected with
// BOUNDED_COUNTER_WRAP_EN.
module tb_bounded_step_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
  localparam int LO     = 10;
  localparam int HI     = 50;

  logic              clk;
  logic              rst;
  logic              start;
  logic              en;
  logic              load;
  logic [WIDTH-1:0]  din;
  logic [STEP_W-1:0] step;
  logic              up_down;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              finish;
  logic              at_bound;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: plain integers, states 0=idle 1=running 2=done.
  int modelCount  = LO;
  int modelState  = 0;
  bit modelFinish = 1'b0;

  typedef struct {
    string            name;
    bit               rst;
    bit               load;
    int               din;
    bit               start;
    bit               en;
    int               step;
    bit               up;
    int               expCount;
    bit               expBusy;
    bit               expFinish;
  } vec_t;

  vec_t vecs[$];

  bounded_step_counter #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W),
    .MIN    (8'd10),
    .MAX    (8'd50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .en       (en),
    .load     (load),
    .din      (din),
    .step     (step),
    .up_down  (up_down),
    .count    (count),
    .busy     (busy),
    .finish   (finish),
    .at_bound (at_bound)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock using the counter rules directly:
  // reset, then clamped load, then start, then a signed-integer step
  // that either lands inside [LO, HI] or counts as a boundary event.
  task automatic modelUpdate();
    int target;
    modelFinish = 1'b0;
    if (rst) begin
      modelCount = LO;
      modelState = 0;
    end else if (load) begin
      modelCount = (int'(din) < LO) ? LO : (int'(din) > HI) ? HI : int'(din);
      modelState = 0;
    end else if (start && modelState != 1) begin
      modelState = 1;
    end else if (modelState == 1 && en) begin
      target = up_down ? modelCount + int'(step) : modelCount - int'(step);
      if ((up_down && (modelCount == HI || target > HI)) ||
          (!up_down && (modelCount == LO || target < LO))) begin
        modelFinish = 1'b1;
`ifdef BOUNDED_COUNTER_WRAP_EN
        modelCount = up_down ? LO : HI;
`else
        modelCount = up_down ? HI : LO;
        modelState = 2;
`endif
      end else begin
        modelCount = target;
      end
    end
  endtask

  // Drive one cycle of inputs on the falling edge, let the rising edge
  // act on them, then move the model along and step 1 ns past the edge.
  task automatic applyStimulus(input bit r, input bit ld, input int d,
                               input bit st, input bit e, input int s,
                               input bit u);
    @(negedge clk);
    rst     = r;
    load    = ld;
    din     = d[WIDTH-1:0];
    start   = st;
    en      = e;
    step    = s[STEP_W-1:0];
    up_down = u;
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  // Compare all four outputs against the required values.
  task automatic checkOutput(input string name, input int expCount,
                             input bit expBusy, input bit expFinish);
    bit expBound;
    expBound = up_down ? (expCount == HI) : (expCount == LO);
    assertCount++;
    if (int'(count) != expCount) begin
      failCount++;
      $display("[TB] FAIL %s count: got %0d, expected %0d", name, count, expCount);
    end
    assertCount++;
    if (busy !== expBusy) begin
      failCount++;
      $display("[TB] FAIL %s busy: got %0b, expected %0b", name, busy, expBusy);
    end
    assertCount++;
    if (finish !== expFinish) begin
      failCount++;
      $display("[TB] FAIL %s finish: got %0b, expected %0b", name, finish, expFinish);
    end
    assertCount++;
    if (at_bound !== expBound) begin
      failCount++;
      $display("[TB] FAIL %s at_bound: got %0b, expected %0b", name, at_bound, expBound);
    end
  endtask

  task automatic addVec(input string n, input bit r, input bit ld, input int d,
                        input bit st, input bit e, input int s, input bit u,
                        input int c, input bit b, input bit f);
    vec_t v;
    v.name = n; v.rst = r; v.load = ld; v.din = d; v.start = st; v.en = e;
    v.step = s; v.up = u; v.expCount = c; v.expBusy = b; v.expFinish = f;
    vecs.push_back(v);
  endtask

  // Main sequence: directed table, a combinational at_bound check,
  // then randomized cycles against the model.
  initial begin
    rst = 1'b0; load = 1'b0; din = '0; start = 1'b0;
    en = 1'b0; step = '0; up_down = 1'b0;

    //     name          rst ld din  st en stp up  cnt busy fin
    addVec("reset",      1, 0,   0, 0, 0, 0, 0,  10, 0, 0);
    addVec("load_lo",    0, 1,   3, 0, 0, 0, 0,  10, 0, 0);
    addVec("load_hi",    0, 1, 200, 0, 0, 0, 0,  50, 0, 0);
    addVec("load_mid",   0, 1,  25, 0, 0, 0, 0,  25, 0, 0);
    addVec("start_up",   0, 0,   0, 1, 1, 4, 1,  25, 1, 0);
    addVec("up_29",      0, 0,   0, 0, 1, 4, 1,  29, 1, 0);
    addVec("up_33",      0, 0,   0, 0, 1, 4, 1,  33, 1, 0);
    addVec("up_37",      0, 0,   0, 0, 1, 4, 1,  37, 1, 0);
    addVec("up_41",      0, 0,   0, 0, 1, 4, 1,  41, 1, 0);
    addVec("up_45",      0, 0,   0, 0, 1, 4, 1,  45, 1, 0);
    addVec("up_49",      0, 0,   0, 0, 1, 4, 1,  49, 1, 0);
`ifdef BOUNDED_COUNTER_WRAP_EN
    addVec("wrap_up",    0, 0,   0, 0, 1, 4, 1,  10, 1, 1);
    addVec("after_wrap", 0, 0,   0, 0, 1, 4, 1,  14, 1, 0);
    addVec("wrap_load",  0, 1,  12, 0, 0, 0, 0,  12, 0, 0);
    addVec("wrap_start", 0, 0,   0, 1, 0, 7, 0,  12, 1, 0);
    addVec("wrap_down",  0, 0,   0, 0, 1, 7, 0,  50, 1, 1);
`else
    addVec("sat_up",     0, 0,   0, 0, 1, 4, 1,  50, 0, 1);
    addVec("done_hold",  0, 0,   0, 0, 1, 4, 1,  50, 0, 0);
    addVec("done_start", 0, 0,   0, 1, 0, 4, 1,  50, 1, 0);
    addVec("bound_step0",0, 0,   0, 0, 1, 0, 1,  50, 0, 1);
    addVec("load_20",    0, 1,  20, 0, 0, 0, 0,  20, 0, 0);
    addVec("start_down", 0, 0,   0, 1, 1, 7, 0,  20, 1, 0);
    addVec("down_13",    0, 0,   0, 0, 1, 7, 0,  13, 1, 0);
    addVec("sat_down",   0, 0,   0, 0, 1, 7, 0,  10, 0, 1);
`endif
    addVec("reload_20",  0, 1,  20, 0, 0, 0, 0,  20, 0, 0);
    addVec("restart_dn", 0, 0,   0, 1, 0, 7, 0,  20, 1, 0);
    addVec("down_13b",   0, 0,   0, 0, 1, 7, 0,  13, 1, 0);
    addVec("load_vs_en", 0, 1,  40, 0, 1, 7, 0,  40, 0, 0);
    addVec("load_33",    0, 1,  33, 0, 0, 0, 1,  33, 0, 0);
    addVec("start_33",   0, 0,   0, 1, 0, 4, 1,  33, 1, 0);
    addVec("up_37b",     0, 0,   0, 0, 1, 4, 1,  37, 1, 0);
    addVec("rst_midrun", 1, 0,   0, 0, 1, 4, 1,  10, 0, 0);
    addVec("post_rst",   0, 0,   0, 0, 1, 4, 1,  10, 0, 0);
    addVec("start_lo",   0, 0,   0, 1, 0, 0, 1,  10, 1, 0);
    addVec("step0_hold", 0, 0,   0, 0, 1, 0, 1,  10, 1, 0);
    addVec("en0_hold",   0, 0,   0, 0, 0, 3, 1,  10, 1, 0);

    // Directed table: each record is applied for one cycle and checked.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].start,
                    vecs[i].en, vecs[i].step, vecs[i].up);
      checkOutput(vecs[i].name, vecs[i].expCount, vecs[i].expBusy,
                  vecs[i].expFinish);
    end

    // at_bound must follow up_down with no clock edge in between.
    @(negedge clk);
    en = 1'b0;
    up_down = 1'b0;
    #1;
    assertCount++;
    if (at_bound !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL comb_bound_down: got %0b, expected 1", at_bound);
    end
    up_down = 1'b1;
    #1;
    assertCount++;
    if (at_bound !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL comb_bound_up: got %0b, expected 0", at_bound);
    end

    // Randomized cycles, checked against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(99) < 2), ($urandom_range(99) < 8),
                    int'($urandom_range(255)), ($urandom_range(99) < 15),
                    ($urandom_range(99) < 75), int'($urandom_range(15)),
                    bit'($urandom_range(1)));
      checkOutput("random", modelCount, (modelState == 1), modelFinish);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
